reg_file_array: RTL and testbench



---
 rtl/reg_file_array.sv | 58 +++++
 tb/tb_reg_file_array.sv | 139 +++++++++++++
 2 files changed

// File: rtl/reg_file_array.sv
// Thirty-one-entry register array (r0 reads as zero) with two registered read ports,
// optional same-edge write-to-read bypass and a sticky flag for non-one-hot write enables.
module reg_file_array #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           REG_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [4:0]            RD_REG_A,
  input  logic [4:0]            RD_REG_B,
  output logic [DATA_WIDTH-1:0] RD_DATA_A,
  output logic [DATA_WIDTH-1:0] RD_DATA_B,
  output logic                  EN_ERR
);

  logic                  en_multi;
  logic [31:1]           we;
  logic [DATA_WIDTH-1:0] regs [1:31];
  logic [DATA_WIDTH-1:0] view [0:31];

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign en_multi = |(REG_EN & (REG_EN - 32'd1));
  // An illegal vector writes nothing; bit 0 alone is a legal no-op.
  assign we       = en_multi ? '0 : REG_EN[31:1];

  // NOTE: the array is reset explicitly because reset must clear architectural state;
  // this keeps it as plain flops rather than an inferred RAM macro.
  for (genvar i = 1; i < 32; i++) begin : g_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset)      regs[i] <= '0;
      else if (we[i]) regs[i] <= WR_DATA;
    end
  end

  // NOTE: every always_comb target is assigned on all paths so no latch is inferred.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      view[i] = (BYPASS && we[i]) ? WR_DATA : regs[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RD_DATA_A <= '0;
      RD_DATA_B <= '0;
      EN_ERR    <= 1'b0;
    end else begin
      RD_DATA_A <= view[RD_REG_A];
      RD_DATA_B <= view[RD_REG_B];
      if (en_multi) EN_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_array.sv
// Directed bench driving one bypassing and one non-bypassing instance with shared stimulus;
// expected read data is queued when a step is driven and compared after the edge.
module tb_reg_file_array;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] REG_EN = '0;
  logic [31:0] WR_DATA = '0;
  logic [4:0]  RD_REG_A = '0;
  logic [4:0]  RD_REG_B = '0;
  logic [31:0] a1, b1, a0, b0;
  logic        err1, err0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] a1, b1, a0, b0;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  reg_file_array #(.DATA_WIDTH(32), .BYPASS(1'b1)) dut_byp (
    .clock(clock), .reset(reset), .REG_EN(REG_EN), .WR_DATA(WR_DATA),
    .RD_REG_A(RD_REG_A), .RD_REG_B(RD_REG_B),
    .RD_DATA_A(a1), .RD_DATA_B(b1), .EN_ERR(err1)
  );

  reg_file_array #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut_nob (
    .clock(clock), .reset(reset), .REG_EN(REG_EN), .WR_DATA(WR_DATA),
    .RD_REG_A(RD_REG_A), .RD_REG_B(RD_REG_B),
    .RD_DATA_A(a0), .RD_DATA_B(b0), .EN_ERR(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue expectations, compare after the edge.
  task automatic step(input string tag, input logic [31:0] en, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic [31:0] ea1, input logic [31:0] eb1,
                      input logic [31:0] ea0, input logic [31:0] eb0, input logic eerr);
    exp_t e;
    REG_EN   = en;
    WR_DATA  = wd;
    RD_REG_A = ra;
    RD_REG_B = rb;
    sb.push_back('{tag, ea1, eb1, ea0, eb0, eerr});
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    check({e.tag, " byp.a"}, a1, e.a1);
    check({e.tag, " byp.b"}, b1, e.b1);
    check({e.tag, " nob.a"}, a0, e.a0);
    check({e.tag, " nob.b"}, b0, e.b0);
    check({e.tag, " byp.err"}, {31'd0, err1}, {31'd0, e.err});
    check({e.tag, " nob.err"}, {31'd0, err0}, {31'd0, e.err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst byp.a", a1, 32'h0);
    check("rst nob.b", b0, 32'h0);
    check("rst err", {31'd0, err1}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic write then read
    step("wr r2",   32'h4, 32'hDEAD_BEEF, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    step("rd r2",   32'h0, 32'h0, 5'd2, 5'd2,
         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    // r0 is not writable and its write is not an error
    step("wr r0",   32'h1, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    step("rd r0",   32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);

    // Same-edge bypass
    step("wr r5",   32'h20, 32'h1111_1111, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    step("byp r5",  32'h20, 32'h2222_2222, 5'd5, 5'd5,
         32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111, 1'b0);
    step("aft r5",  32'h0, 32'h0, 5'd5, 5'd5,
         32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 1'b0);

    // Illegal vector: no write, sticky error, no bypass
    step("wr r3",   32'h8,  32'hA, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    step("wr r4",   32'h10, 32'hB, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    step("illegal", 32'h18, 32'hC, 5'd3, 5'd4, 32'hA, 32'hB, 32'hA, 32'hB, 1'b1);
    step("ill rd",  32'h0,  32'h0, 5'd3, 5'd4, 32'hA, 32'hB, 32'hA, 32'hB, 1'b1);
    step("wr r7",   32'h80, 32'h7, 5'd7, 5'd0, 32'h7, 0, 32'h0, 0, 1'b1);
    step("rd r7",   32'h0,  32'h0, 5'd7, 5'd7, 32'h7, 32'h7, 32'h7, 32'h7, 1'b1);

    // Asynchronous reset between edges
    step("wr r31",  32'h8000_0000, 32'h5, 5'd31, 5'd0, 32'h5, 0, 32'h0, 0, 1'b1);
    step("rd r31",  32'h0, 32'h0, 5'd31, 5'd31, 32'h5, 32'h5, 32'h5, 32'h5, 1'b1);
    #2;
    reset   = 1'b1;
    REG_EN  = 32'h4000_0000;
    WR_DATA = 32'h9;
    #1;
    check("arst byp.a", a1, 32'h0);
    check("arst nob.a", a0, 32'h0);
    check("arst byp.err", {31'd0, err1}, 32'h0);
    check("arst nob.err", {31'd0, err0}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step("post rst", 32'h0, 32'h0, 5'd31, 5'd30, 0, 0, 0, 0, 1'b0);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      step("sweep wr", 32'd1 << i, i * 32'h0101_0101, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      step("sweep rd", 32'h0, 32'h0, 5'(i), 5'(31 - i),
           i * 32'h0101_0101, (31 - i) * 32'h0101_0101,
           i * 32'h0101_0101, (31 - i) * 32'h0101_0101, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
